alu_control_sequencer: RTL and testbench

- Multi-cycle control sequencer that drives the 8-bit ALU and the register file of the lab CPU.
- Accepts one 32-bit instruction at a time over a valid/ready handshake and decodes it.
- Issues register read addresses, ALU select, immediate and negate controls, and holds them while the ALU settles.
- Finishes with a register-file write, a PC-increment pulse or a branch request.
- Consumes the ALU ZERO flag to resolve beq.

---
 rtl/alu_control_sequencer_if.sv | 34 +++
 rtl/alu_control_sequencer.sv | 148 ++++++++++++++
 tb/tb_alu_control_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_control_sequencer_if.sv
// Instruction handshake and ALU/register-file control bundle of the lab CPU sequencer.
// slave is the sequencer side, master is the instruction source / datapath side.
interface alu_control_sequencer_if;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic        ZERO;
  logic [2:0]  READ_ADDR1;
  logic [2:0]  READ_ADDR2;
  logic [2:0]  ALUOP;
  logic        IMM_SEL;
  logic        NEG_SEL;
  logic [7:0]  IMMEDIATE;
  logic        WRITE_EN;
  logic [2:0]  WRITE_ADDR;
  logic        PC_INC;
  logic        BRANCH_TAKEN;
  logic [7:0]  BRANCH_OFFSET;
  logic        ILLEGAL;

  modport slave (
    input  INSTRUCTION, INSTR_VALID, ZERO,
    output INSTR_READY, READ_ADDR1, READ_ADDR2, ALUOP, IMM_SEL, NEG_SEL,
           IMMEDIATE, WRITE_EN, WRITE_ADDR, PC_INC, BRANCH_TAKEN,
           BRANCH_OFFSET, ILLEGAL
  );

  modport master (
    output INSTRUCTION, INSTR_VALID, ZERO,
    input  INSTR_READY, READ_ADDR1, READ_ADDR2, ALUOP, IMM_SEL, NEG_SEL,
           IMMEDIATE, WRITE_EN, WRITE_ADDR, PC_INC, BRANCH_TAKEN,
           BRANCH_OFFSET, ILLEGAL
  );
endinterface

// File: rtl/alu_control_sequencer.sv
// Multi-cycle decode/execute/writeback sequencer driving the 8-bit ALU and register file.
// Controls are held for ALU_WAIT_CYCLES EXECUTE cycles; beq resolves on ZERO at the last one.
module alu_control_sequencer #(
  parameter int unsigned ALU_WAIT_CYCLES = 2
) (
  input logic                   CLK,
  input logic                   RESET,
  alu_control_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} state_t;

  typedef enum logic [7:0] {
    OP_LOADI = 8'h00,
    OP_MOV   = 8'h01,
    OP_ADD   = 8'h02,
    OP_SUB   = 8'h03,
    OP_AND   = 8'h04,
    OP_OR    = 8'h05,
    OP_J     = 8'h06,
    OP_BEQ   = 8'h07
  } opcode_t;

  localparam logic [2:0] SEL_FWD = 3'b000;
  localparam logic [2:0] SEL_ADD = 3'b001;
  localparam logic [2:0] SEL_AND = 3'b010;
  localparam logic [2:0] SEL_OR  = 3'b011;

  localparam logic [2:0] WAIT_LOAD = 3'(ALU_WAIT_CYCLES - 1);

  state_t      state;
  logic [31:0] instr_q;
  logic [2:0]  wait_cnt;
  logic [2:0]  aluop_q;
  logic        imm_sel_q;
  logic        neg_sel_q;
  logic        write_en_q;
  logic        pc_inc_q;
  logic        branch_q;
  logic        illegal_q;
  logic [7:0]  op_in;
  logic [7:0]  op_q;
  logic [4:0]  ctrl_in;
  logic        unused_rt_hi;

  assign op_in = bus.INSTRUCTION[31:24];
  assign op_q  = instr_q[31:24];

  // {ALUOP, IMM_SEL, NEG_SEL}; undefined opcodes leave the ALU controls at zero.
  function automatic logic [4:0] decode_ctrl(input logic [7:0] op);
    logic [4:0] c;
    c = '0;
    case (op)
      OP_LOADI: c = {SEL_FWD, 1'b1, 1'b0};
      OP_MOV:   c = {SEL_FWD, 1'b0, 1'b0};
      OP_ADD:   c = {SEL_ADD, 1'b0, 1'b0};
      OP_SUB:   c = {SEL_ADD, 1'b0, 1'b1};
      OP_AND:   c = {SEL_AND, 1'b0, 1'b0};
      OP_OR:    c = {SEL_OR,  1'b0, 1'b0};
      OP_J:     c = {SEL_FWD, 1'b0, 1'b0};
      OP_BEQ:   c = {SEL_ADD, 1'b0, 1'b1};
      default:  c = '0;
    endcase
    return c;
  endfunction

  assign ctrl_in = decode_ctrl(op_in);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      instr_q    <= '0;
      wait_cnt   <= '0;
      aluop_q    <= '0;
      imm_sel_q  <= 1'b0;
      neg_sel_q  <= 1'b0;
      write_en_q <= 1'b0;
      pc_inc_q   <= 1'b0;
      branch_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      write_en_q <= 1'b0;
      pc_inc_q   <= 1'b0;
      branch_q   <= 1'b0;
      illegal_q  <= 1'b0;
      case (state)
        IDLE: begin
          // ALU controls are registered at accept so they are already valid in DECODE.
          if (bus.INSTR_VALID) begin
            instr_q                         <= bus.INSTRUCTION;
            {aluop_q, imm_sel_q, neg_sel_q} <= ctrl_in;
            illegal_q                       <= (op_in > 8'h07);
            state                           <= DECODE;
          end
        end
        DECODE: begin
          if (op_q > 8'h07) begin
            state <= IDLE;
          end else begin
            wait_cnt <= WAIT_LOAD;
            state    <= EXECUTE;
          end
        end
        EXECUTE: begin
          if (wait_cnt == '0) begin
            aluop_q   <= '0;
            imm_sel_q <= 1'b0;
            neg_sel_q <= 1'b0;
            state     <= WRITEBACK;
            case (op_q)
              OP_J:    branch_q <= 1'b1;
              OP_BEQ: begin
                branch_q <= bus.ZERO;
                pc_inc_q <= ~bus.ZERO;
              end
              default: begin
                write_en_q <= 1'b1;
                pc_inc_q   <= 1'b1;
              end
            endcase
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        WRITEBACK: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // Ready is gated by RESET so it is low in every reset cycle, yet high right after.
  assign bus.INSTR_READY   = (state == IDLE) && !RESET;
  assign bus.READ_ADDR1    = instr_q[10:8];
  assign bus.READ_ADDR2    = instr_q[2:0];
  assign bus.IMMEDIATE     = instr_q[7:0];
  assign bus.WRITE_ADDR    = instr_q[18:16];
  assign bus.BRANCH_OFFSET = instr_q[23:16];
  assign bus.ALUOP         = aluop_q;
  assign bus.IMM_SEL       = imm_sel_q;
  assign bus.NEG_SEL       = neg_sel_q;
  assign bus.WRITE_EN      = write_en_q;
  assign bus.PC_INC        = pc_inc_q;
  assign bus.BRANCH_TAKEN  = branch_q;
  assign bus.ILLEGAL       = illegal_q;

  assign unused_rt_hi = &{1'b0, instr_q[15:11]};

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed bench for alu_control_sequencer: strobe packets scoreboarded by a negedge monitor,
// ALU control timing checked at fixed cycles after each accept.
module tb_alu_control_sequencer;

  localparam int unsigned W = 2;

  typedef struct packed {
    logic       we;
    logic       pc;
    logic       br;
    logic       ill;
    logic [2:0] waddr;
    logic [7:0] off;
    logic [3:0] lat;
  } pkt_t;

  logic CLK = 1'b0;
  logic RESET;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   acc     = 0;
  pkt_t sb[$];

  alu_control_sequencer_if bus ();

  alu_control_sequencer #(.ALU_WAIT_CYCLES(W)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic pkt_t model(input logic [31:0] ins, input logic z);
    pkt_t p;
    logic [7:0] op;
    op      = ins[31:24];
    p       = '0;
    p.waddr = ins[18:16];
    p.off   = ins[23:16];
    if (op > 8'h07) begin
      p.ill = 1'b1;
      p.lat = 4'd1;
    end else begin
      p.lat = 4'(2 + W);
      case (op)
        8'h06: p.br = 1'b1;
        8'h07: begin
          p.br = z;
          p.pc = ~z;
        end
        default: begin
          p.we = 1'b1;
          p.pc = 1'b1;
        end
      endcase
    end
    return p;
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({bus.READ_ADDR1, bus.READ_ADDR2, bus.ALUOP, bus.IMM_SEL, bus.NEG_SEL,
                bus.IMMEDIATE, bus.WRITE_EN, bus.WRITE_ADDR, bus.PC_INC,
                bus.BRANCH_TAKEN, bus.BRANCH_OFFSET, bus.ILLEGAL});
  endfunction

  function automatic logic [63:0] alu_ctrl();
    return 64'({bus.ALUOP, bus.IMM_SEL, bus.NEG_SEL});
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 16; i++) begin
      if (bus.INSTR_READY) break;
      tick();
    end
    chk("ready_wait", 64'(bus.INSTR_READY), 64'd1);
  endtask

  // Strobe monitor: latency is counted from the IDLE cycle in which the accept was seen.
  always @(negedge CLK) begin
    pkt_t obs;
    pkt_t exp;
    cyc++;
    if (!RESET) begin
      if (bus.INSTR_READY && bus.INSTR_VALID) acc = cyc;
      if (bus.WRITE_EN || bus.PC_INC || bus.BRANCH_TAKEN || bus.ILLEGAL) begin
        obs = '{we: bus.WRITE_EN, pc: bus.PC_INC, br: bus.BRANCH_TAKEN, ill: bus.ILLEGAL,
                waddr: bus.WRITE_ADDR, off: bus.BRANCH_OFFSET, lat: 4'(cyc - acc)};
        if (sb.size() == 0) begin
          chk("unexpected_strobe",
              64'({bus.WRITE_EN, bus.PC_INC, bus.BRANCH_TAKEN, bus.ILLEGAL}), 64'd0);
        end else begin
          exp = sb.pop_front();
          chk("sb_packet", 64'(obs), 64'(exp));
        end
      end
    end
  end

  initial begin
    RESET           = 1'b1;
    bus.INSTR_VALID = 1'b0;
    bus.INSTRUCTION = '0;
    bus.ZERO        = 1'b0;
    tick();
    tick();
    chk("reset_ready_low", 64'(bus.INSTR_READY), 64'd0);
    chk("reset_outs_zero", all_outs(), 64'd0);
    RESET = 1'b0;
    #1;
    chk("ready_after_reset", 64'(bus.INSTR_READY), 64'd1);

    // loadi r3, 0x2A
    bus.INSTRUCTION = 32'h0003002A;
    bus.INSTR_VALID = 1'b1;
    sb.push_back(model(32'h0003002A, 1'b0));
    tick();
    bus.INSTR_VALID = 1'b0;
    chk("loadi_imm", 64'(bus.IMMEDIATE), 64'h2A);
    chk("loadi_waddr", 64'(bus.WRITE_ADDR), 64'd3);
    chk("loadi_busy", 64'(bus.INSTR_READY), 64'd0);
    tick();
    chk("loadi_ex1_ctrl", alu_ctrl(), 64'b000_1_0);
    chk("loadi_ex1_we", 64'(bus.WRITE_EN), 64'd0);
    tick();
    chk("loadi_ex2_ctrl", alu_ctrl(), 64'b000_1_0);
    chk("loadi_ex2_we", 64'(bus.WRITE_EN), 64'd0);
    tick();
    chk("loadi_wb_strobes", 64'({bus.WRITE_EN, bus.PC_INC}), 64'b11);
    chk("loadi_wb_ctrl", alu_ctrl(), 64'd0);
    tick();
    chk("loadi_after_we", 64'(bus.WRITE_EN), 64'd0);

    // sub r1, r2, r4
    wait_ready();
    bus.INSTRUCTION = 32'h03010204;
    bus.INSTR_VALID = 1'b1;
    sb.push_back(model(32'h03010204, 1'b0));
    tick();
    bus.INSTR_VALID = 1'b0;
    chk("sub_raddr", 64'({bus.READ_ADDR1, bus.READ_ADDR2}), 64'({3'd2, 3'd4}));
    chk("sub_dec_ctrl", alu_ctrl(), 64'b001_0_1);
    tick();
    chk("sub_ex_ctrl", alu_ctrl(), 64'b001_0_1);
    chk("sub_waddr", 64'(bus.WRITE_ADDR), 64'd1);
    tick();
    tick();
    chk("sub_wb_we", 64'(bus.WRITE_EN), 64'd1);
    tick();
    chk("sub_single_we", 64'(bus.WRITE_EN), 64'd0);

    // beq taken: ZERO only high across the last EXECUTE edge
    wait_ready();
    bus.INSTRUCTION = 32'h07FC0102;
    bus.INSTR_VALID = 1'b1;
    bus.ZERO        = 1'b0;
    sb.push_back(model(32'h07FC0102, 1'b1));
    tick();
    bus.INSTR_VALID = 1'b0;
    tick();
    chk("beq_ex_ctrl", alu_ctrl(), 64'b001_0_1);
    tick();
    bus.ZERO = 1'b1;
    tick();
    bus.ZERO = 1'b0;
    chk("beq_t_strobes", 64'({bus.BRANCH_TAKEN, bus.PC_INC, bus.WRITE_EN}), 64'b100);
    chk("beq_t_offset", 64'(bus.BRANCH_OFFSET), 64'hFC);

    // beq not taken: ZERO high early, low at the last EXECUTE edge
    wait_ready();
    bus.INSTR_VALID = 1'b1;
    sb.push_back(model(32'h07FC0102, 1'b0));
    tick();
    bus.INSTR_VALID = 1'b0;
    tick();
    bus.ZERO = 1'b1;
    tick();
    bus.ZERO = 1'b0;
    tick();
    chk("beq_nt_strobes", 64'({bus.BRANCH_TAKEN, bus.PC_INC, bus.WRITE_EN}), 64'b010);

    // illegal opcode
    wait_ready();
    bus.INSTRUCTION = 32'h09000000;
    bus.INSTR_VALID = 1'b1;
    sb.push_back(model(32'h09000000, 1'b0));
    tick();
    bus.INSTR_VALID = 1'b0;
    chk("ill_pulse", 64'({bus.ILLEGAL, bus.INSTR_READY}), 64'b10);
    tick();
    chk("ill_done", 64'({bus.ILLEGAL, bus.INSTR_READY}), 64'b01);

    // reset for two cycles in the middle of an add
    bus.INSTRUCTION = 32'h02010203;
    bus.INSTR_VALID = 1'b1;
    tick();
    bus.INSTR_VALID = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    chk("rst_mid_outs", all_outs(), 64'd0);
    tick();
    RESET = 1'b0;
    #1;
    chk("rst_mid_ready", 64'(bus.INSTR_READY), 64'd1);
    chk("rst_mid_quiet", all_outs(), 64'd0);
    tick();
    tick();
    tick();

    // back-to-back with INSTRUCTION changed mid-flight
    wait_ready();
    bus.INSTRUCTION = 32'h02010203;
    bus.INSTR_VALID = 1'b1;
    sb.push_back(model(32'h02010203, 1'b0));
    tick();
    tick();
    bus.INSTRUCTION = 32'h05020304;
    sb.push_back(model(32'h05020304, 1'b0));
    chk("b2b_first_ctrl", alu_ctrl(), 64'b001_0_0);
    tick();
    chk("b2b_first_waddr", 64'(bus.WRITE_ADDR), 64'd1);
    tick();
    chk("b2b_first_we", 64'({bus.WRITE_EN, bus.WRITE_ADDR}), 64'({1'b1, 3'd1}));
    tick();
    chk("b2b_idle_ready", 64'(bus.INSTR_READY), 64'd1);
    tick();
    bus.INSTR_VALID = 1'b0;
    chk("b2b_second_waddr", 64'(bus.WRITE_ADDR), 64'd2);
    tick();
    chk("b2b_second_ctrl", alu_ctrl(), 64'b011_0_0);
    tick();
    tick();
    tick();
    tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
